// File: rtl/r22sdf_bf2i.sv
// Radix-2^2 SDF first butterfly (BF2I) with feedback delay line of DEPTH samples.
// Optional macro R22SDF_BF2I_SAT_EN: saturate add/sub results instead of wrapping.
`timescale 1ns/1ps

package R22SdfDefinesPkg;
    localparam int DW = 16;
    localparam int FW = 15;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    function automatic logic signed [DW:0] addw(logic signed [DW-1:0] a, logic signed [DW-1:0] b,
                                                logic sc);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        return sc ? (s >>> 1) : s;
    endfunction

    function automatic logic signed [DW:0] subw(logic signed [DW-1:0] a, logic signed [DW-1:0] b,
                                                logic sc);
        logic signed [DW:0] s;
        s = {a[DW-1], a} - {b[DW-1], b};
        return sc ? (s >>> 1) : s;
    endfunction

    function automatic cplx_t cadd(cplx_t a, cplx_t b, logic sc);
        logic signed [DW:0] r;
        logic signed [DW:0] i;
        r = addw(a.re, b.re, sc);
        i = addw(a.im, b.im, sc);
        return '{re: r[DW-1:0], im: i[DW-1:0]};
    endfunction

    function automatic cplx_t csub(cplx_t a, cplx_t b, logic sc);
        logic signed [DW:0] r;
        logic signed [DW:0] i;
        r = subw(a.re, b.re, sc);
        i = subw(a.im, b.im, sc);
        return '{re: r[DW-1:0], im: i[DW-1:0]};
    endfunction
endpackage

module r22sdf_bf2i
    import R22SdfDefinesPkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  cplx_t in_data,
    input  logic  sc,
    output logic  out_valid,
    output cplx_t out_data,
    output logic  out_sof
);
    localparam int unsigned CW = $clog2(2 * DEPTH);

    logic [CW-1:0] ctr_q;
    logic          primed_q;
    cplx_t         line_q [DEPTH];
    cplx_t         head;
    cplx_t         cand;
    cplx_t         push;
    logic          phase;
    logic          at_mid;
    logic          fire;

    function automatic logic signed [DW-1:0] fit(logic signed [DW:0] v);
`ifdef R22SDF_BF2I_SAT_EN
        if (v[DW] != v[DW-1]) begin
            return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
        return v[DW-1:0];
    endfunction

    assign head   = line_q[DEPTH-1];
    assign phase  = ctr_q[CW-1];
    assign at_mid = (ctr_q == CW'(DEPTH));
    // The first output ever emitted is the sum formed at the frame midpoint.
    assign fire   = in_valid && (primed_q || at_mid);

    always_comb begin
        cand = head;
        push = in_data;
        if (phase) begin
            cand.re = fit(addw(head.re, in_data.re, sc));
            cand.im = fit(addw(head.im, in_data.im, sc));
            push.re = fit(subw(head.re, in_data.re, sc));
            push.im = fit(subw(head.im, in_data.im, sc));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q     <= '0;
            primed_q  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= fire;
            out_sof   <= in_valid && at_mid;
            if (in_valid) begin
                ctr_q <= ctr_q + CW'(1);
                if (at_mid) begin
                    primed_q <= 1'b1;
                end
            end
            if (fire) begin
                out_data <= cand;
            end
        end
    end

    // Delay line carries no reset; its contents are never output until primed.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                line_q[i] <= line_q[i-1];
            end
            line_q[0] <= push;
        end
    end
endmodule

// File: tb/tb_r22sdf_bf2i.sv
// Scoreboard bench for r22sdf_bf2i: one DEPTH=4 and one DEPTH=8 instance.
`timescale 1ns/1ps

module tb_r22sdf_bf2i;
    import R22SdfDefinesPkg::*;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        sof;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  v4 = 1'b0, sc4 = 1'b0, v8 = 1'b0, sc8 = 1'b0;
    cplx_t d4 = '0, d8 = '0;
    logic  ov4, sof4, ov8, sof8;
    cplx_t od4, od8;

    r22sdf_bf2i #(.DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .sc(sc4),
        .out_valid(ov4), .out_data(od4), .out_sof(sof4)
    );
    r22sdf_bf2i #(.DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .sc(sc8),
        .out_valid(ov8), .out_data(od8), .out_sof(sof8)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   n8 = 0;
    exp_t q4[$], q8[$], obs4[$];
    exp_t e4, e8, o4;
    logic fire4 = 1'b0, fire8 = 1'b0, ev4 = 1'b0, ev8 = 1'b0, rq = 1'b0;
    logic [31:0] last4 = '0, last8 = '0;

    int   mctr[2];
    bit   mprimed[2];
    logic signed [15:0] fh_re[2][8], fh_im[2][8], df_re[2][8], df_im[2][8];

    function automatic logic [15:0] red(int v, logic s);
        int r;
        r = s ? (v >>> 1) : v;
`ifdef R22SDF_BF2I_SAT_EN
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        rq  <= rst;
        ev4 <= rst ? 1'b0 : fire4;
        ev8 <= rst ? 1'b0 : fire8;
    end

    always @(negedge clk) begin
        if (rq) begin
            total++;
            if (ov4 !== 1'b0 || sof4 !== 1'b0 || od4 !== 32'h0) begin
                bad++;
                $display("FAIL reset4: got v=%b sof=%b d=%h, want 0 0 0", ov4, sof4, od4);
            end
            last4 = '0;
        end else begin
            total++;
            if (ov4 !== ev4) begin
                bad++;
                $display("FAIL valid4: got %b want %b at %0t", ov4, ev4, $time);
            end
            if (ov4 === 1'b1) begin
                o4.re = od4.re; o4.im = od4.im; o4.sof = sof4;
                obs4.push_back(o4);
                total++;
                if (q4.size() == 0) begin
                    bad++;
                    $display("FAIL extra4: got output %h with empty queue, want none", od4);
                end else begin
                    e4 = q4.pop_front();
                    if ({od4.re, od4.im, sof4} !== {e4.re, e4.im, e4.sof}) begin
                        bad++;
                        $display("FAIL data4: got %h/%h sof=%b want %h/%h sof=%b",
                                 od4.re, od4.im, sof4, e4.re, e4.im, e4.sof);
                    end
                    last4 = {e4.re, e4.im};
                end
            end else if (ev4 === 1'b0) begin
                total++;
                if (od4 !== last4 || sof4 !== 1'b0) begin
                    bad++;
                    $display("FAIL hold4: got %h sof=%b want %h sof=0", od4, sof4, last4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rq) begin
            total++;
            if (ov8 !== 1'b0 || sof8 !== 1'b0 || od8 !== 32'h0) begin
                bad++;
                $display("FAIL reset8: got v=%b sof=%b d=%h, want 0 0 0", ov8, sof8, od8);
            end
            last8 = '0;
        end else begin
            total++;
            if (ov8 !== ev8) begin
                bad++;
                $display("FAIL valid8: got %b want %b at %0t", ov8, ev8, $time);
            end
            if (ov8 === 1'b1) begin
                n8++;
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL extra8: got output %h with empty queue, want none", od8);
                end else begin
                    e8 = q8.pop_front();
                    if ({od8.re, od8.im, sof8} !== {e8.re, e8.im, e8.sof}) begin
                        bad++;
                        $display("FAIL data8: got %h/%h sof=%b want %h/%h sof=%b",
                                 od8.re, od8.im, sof8, e8.re, e8.im, e8.sof);
                    end
                    last8 = {e8.re, e8.im};
                end
            end else if (ev8 === 1'b0) begin
                total++;
                if (od8 !== last8 || sof8 !== 1'b0) begin
                    bad++;
                    $display("FAIL hold8: got %h sof=%b want %h sof=0", od8, sof8, last8);
                end
            end
        end
    end

    // Frame model: keep first-half samples by index, form sums/differences at the second half.
    task automatic model(int sel, logic signed [15:0] re, logic signed [15:0] im, logic s,
                         output logic f);
        int   dd;
        int   c;
        exp_t e;
        dd = (sel != 0) ? 8 : 4;
        c  = mctr[sel];
        f  = mprimed[sel] || (c == dd);
        if (c < dd) begin
            if (f) begin
                e.re = df_re[sel][c]; e.im = df_im[sel][c]; e.sof = 1'b0;
                if (sel != 0) q8.push_back(e); else q4.push_back(e);
            end
            fh_re[sel][c] = re;
            fh_im[sel][c] = im;
        end else begin
            e.re  = red(int'(fh_re[sel][c-dd]) + int'(re), s);
            e.im  = red(int'(fh_im[sel][c-dd]) + int'(im), s);
            e.sof = (c == dd);
            if (sel != 0) q8.push_back(e); else q4.push_back(e);
            df_re[sel][c-dd] = red(int'(fh_re[sel][c-dd]) - int'(re), s);
            df_im[sel][c-dd] = red(int'(fh_im[sel][c-dd]) - int'(im), s);
            mprimed[sel] = 1'b1;
        end
        mctr[sel] = (c + 1) % (2 * dd);
    endtask

    task automatic cyc(int sel, logic v, logic signed [15:0] re, logic signed [15:0] im, logic s);
        logic f;
        @(posedge clk);
        #1;
        v4 = 1'b0; v8 = 1'b0; fire4 = 1'b0; fire8 = 1'b0;
        f = 1'b0;
        if (v) model(sel, re, im, s, f);
        if (sel != 0) begin
            v8 = v; d8.re = re; d8.im = im; sc8 = s; fire8 = f;
        end else begin
            v4 = v; d4.re = re; d4.im = im; sc4 = s; fire4 = f;
        end
    endtask

    task automatic do_reset(logic vin);
        @(posedge clk);
        #1;
        rst = 1'b1; v4 = vin; d4.re = 16'sd99; d4.im = 16'sd7; v8 = vin;
        fire4 = 1'b0; fire8 = 1'b0;
        @(posedge clk);
        #1;
        v4 = 1'b0; v8 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mctr = '{0, 0};
        mprimed = '{0, 0};
    endtask

    task automatic run_ramp(logic s, int frames, bit gaps);
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < 8; i++) begin
                if (gaps) repeat ($urandom_range(1, 3)) cyc(0, 1'b0, 16'sd0, 16'sd0, 1'b0);
                cyc(0, 1'b1, 16'(i + 1), 16'sd0, s);
            end
        end
        repeat (3) cyc(0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        total++;
        if (ov4 !== 1'b0 || sof4 !== 1'b0 || od4 !== 32'h0 || ov8 !== 1'b0 || od8 !== 32'h0) begin
            bad++;
            $display("FAIL test_reset: got v4=%b sof4=%b d4=%h v8=%b d8=%h want all 0",
                     ov4, sof4, od4, ov8, od8);
        end
    endtask

    task automatic test_sum_diff();
        int lit[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        do_reset(1'b0);
        obs4.delete();
        run_ramp(1'b0, 2, 1'b0);
        total++;
        if (obs4.size() != 12) begin
            bad++;
            $display("FAIL sum_diff count: got %0d want 12", obs4.size());
        end
        for (int i = 0; i < 8 && i < obs4.size(); i++) begin
            total++;
            if (obs4[i].re !== 16'(lit[i]) || obs4[i].im !== 16'h0 || obs4[i].sof !== (i == 0)) begin
                bad++;
                $display("FAIL sum_diff[%0d]: got %h/%h sof=%b want %h/0000 sof=%b",
                         i, obs4[i].re, obs4[i].im, obs4[i].sof, 16'(lit[i]), i == 0);
            end
        end
    endtask

    task automatic test_scale();
        int lit[8] = '{3, 4, 5, 6, -2, -2, -2, -2};
        do_reset(1'b0);
        obs4.delete();
        run_ramp(1'b1, 2, 1'b0);
        for (int i = 0; i < 8 && i < obs4.size(); i++) begin
            total++;
            if (obs4[i].re !== 16'(lit[i]) || obs4[i].sof !== (i == 0)) begin
                bad++;
                $display("FAIL scale[%0d]: got %h sof=%b want %h sof=%b",
                         i, obs4[i].re, obs4[i].sof, 16'(lit[i]), i == 0);
            end
        end
        total++;
        if (obs4.size() != 12) begin
            bad++;
            $display("FAIL scale count: got %0d want 12", obs4.size());
        end
    endtask

    task automatic test_gaps();
        int lit[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        do_reset(1'b0);
        obs4.delete();
        run_ramp(1'b0, 2, 1'b1);
        total++;
        if (obs4.size() != 12) begin
            bad++;
            $display("FAIL gaps count: got %0d want 12", obs4.size());
        end
        for (int i = 0; i < 8 && i < obs4.size(); i++) begin
            total++;
            if (obs4[i].re !== 16'(lit[i])) begin
                bad++;
                $display("FAIL gaps[%0d]: got %h want %h", i, obs4[i].re, 16'(lit[i]));
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want_re, want_im;
`ifdef R22SDF_BF2I_SAT_EN
        want_re = 16'h7FFF; want_im = 16'h8000;
`else
        want_re = 16'hFFFE; want_im = 16'h0000;
`endif
        do_reset(1'b0);
        obs4.delete();
        for (int i = 0; i < 12; i++) cyc(0, 1'b1, 16'sh7FFF, 16'sh8000, 1'b0);
        repeat (3) cyc(0, 1'b0, 16'sd0, 16'sd0, 1'b0);
        total++;
        if (obs4.size() < 1 || obs4[0].re !== want_re || obs4[0].im !== want_im) begin
            bad++;
            $display("FAIL overflow: got %0d outputs first %h/%h want %h/%h", obs4.size(),
                     obs4.size() > 0 ? obs4[0].re : 16'hx, obs4.size() > 0 ? obs4[0].im : 16'hx,
                     want_re, want_im);
        end
    endtask

    task automatic test_reset_mid();
        int lit[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 16'(i + 1), 16'sd0, 1'b0);
        do_reset(1'b0);
        obs4.delete();
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 16'(i + 1), 16'sd0, 1'b0);
        repeat (2) cyc(0, 1'b0, 16'sd0, 16'sd0, 1'b0);
        total++;
        if (obs4.size() != 0) begin
            bad++;
            $display("FAIL reset_mid early: got %0d outputs want 0", obs4.size());
        end
        for (int i = 4; i < 8; i++) cyc(0, 1'b1, 16'(i + 1), 16'sd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 16'(i + 1), 16'sd0, 1'b0);
        repeat (3) cyc(0, 1'b0, 16'sd0, 16'sd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= obs4.size() || obs4[i].re !== 16'(lit[i])) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i,
                         i < obs4.size() ? obs4[i].re : 16'hx, 16'(lit[i]));
            end
        end
    endtask

    task automatic test_valid_in_reset();
        do_reset(1'b1);
        obs4.delete();
        run_ramp(1'b0, 1, 1'b0);
        total++;
        if (obs4.size() != 4 || obs4[0].re !== 16'd6 || obs4[0].sof !== 1'b1) begin
            bad++;
            $display("FAIL valid_in_reset: got %0d outputs first %h want 4 outputs first 0006",
                     obs4.size(), obs4.size() > 0 ? obs4[0].re : 16'hx);
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        n8 = 0;
        for (int i = 0; i < 64 * 16; i++) begin
            if ($urandom_range(0, 7) == 0) cyc(1, 1'b0, 16'sd0, 16'sd0, 1'b0);
            cyc(1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (3) cyc(1, 1'b0, 16'sd0, 16'sd0, 1'b0);
        total++;
        if (n8 != 1016 || q8.size() != 0) begin
            bad++;
            $display("FAIL random: got %0d outputs, %0d pending want 1016, 0", n8, q8.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        mctr = '{0, 0};
        mprimed = '{0, 0};
        test_reset();
        test_sum_diff();
        test_scale();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_valid_in_reset();
        test_random();
        total++;
        if (q4.size() != 0) begin
            bad++;
            $display("FAIL drain4: got %0d pending want 0", q4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
